// File: rtl/mcu_l2_pkg.sv
// mcu_l2_pkg: shared L2 geometry constants and refill engine state type
package mcu_l2_pkg;
  localparam logic [11:0] L2_HW_MAX = 12'hFFF;
  localparam int L2_WORDS = 512;
  localparam int L2_WORD_BYTES = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} refill_state_t;
endpackage

// File: rtl/l2_ddr_refill_ctrl.sv
// l2_ddr_refill_ctrl: space-checked DDR burst refill streaming into L2 port B
module l2_ddr_refill_ctrl
  import mcu_l2_pkg::*;
#(
  parameter int DDR_ADDR_W = 28,
  parameter int BURST_WORDS = 8,
  parameter int MAX_BURSTS = 4
) (
  input  logic                  clk_166M66,
  input  logic                  mcu_sys_rst,
  input  logic                  i_refill_start,
  input  logic                  i_refill_stop,
  input  logic [DDR_ADDR_W-1:0] i_refill_addr,
  input  logic [11:0]           i_l2_unread_size,
  input  logic                  i_l1ddr_rw_confilicts,
  output logic                  o_ddr_cmd_valid,
  input  logic                  i_ddr_cmd_ready,
  output logic [DDR_ADDR_W-1:0] o_ddr_cmd_addr,
  input  logic                  i_ddr_rd_valid,
  input  logic [127:0]          i_ddr_rd_data,
  output logic                  o_l2_ddr_operate_enable,
  output logic                  o_l2_ddr_rw,
  inout  wire  [127:0]          io_l2_ddr_data_bus,
  output logic                  o_busy,
  output logic                  o_err_unexpected
);
  refill_state_t state;
  logic [9:0] pending;
  logic [7:0] bursts_in_flight;
  logic [6:0] word_cnt;
  logic [127:0] wr_data;
  logic [12:0] free_words;
  logic accept, burst_done, issue, start_ok, nothing_owed;
  assign o_l2_ddr_rw = o_l2_ddr_operate_enable;
  assign o_busy = state != IDLE;
  // A word in the L2 write stage is already consumed, so it no longer backs a new return
  always_comb begin
    free_words = ({1'b0, L2_HW_MAX} - {1'b0, i_l2_unread_size}) >> 3;
    accept = o_ddr_cmd_valid && i_ddr_cmd_ready;
    burst_done = o_l2_ddr_operate_enable && word_cnt == 7'(BURST_WORDS - 1);
    start_ok = state == IDLE && i_refill_start && !i_refill_stop;
    nothing_owed = pending == {9'd0, o_l2_ddr_operate_enable};
    issue = state == RUN && !o_ddr_cmd_valid && !i_l1ddr_rw_confilicts &&
            ({3'd0, pending} + 13'(BURST_WORDS) <= free_words) &&
            bursts_in_flight < 8'(MAX_BURSTS);
  end
  // Engine state, command handshake, in-flight accounting and registered L2 write stage
  always_ff @(posedge clk_166M66 or posedge mcu_sys_rst) begin
    if (mcu_sys_rst) begin
      state <= IDLE;
      o_ddr_cmd_valid <= 1'b0;
      o_ddr_cmd_addr <= '0;
      pending <= '0;
      bursts_in_flight <= '0;
      word_cnt <= '0;
      o_l2_ddr_operate_enable <= 1'b0;
      wr_data <= '0;
      o_err_unexpected <= 1'b0;
    end else begin
      state <= state == IDLE ? (start_ok ? RUN : IDLE) :
               state == RUN ? (i_refill_stop ? DRAIN : RUN) :
               (pending == 10'd0 && !o_ddr_cmd_valid) ? IDLE : DRAIN;
      if (start_ok) o_ddr_cmd_addr <= i_refill_addr & ~DDR_ADDR_W'(4'hF);
      else if (accept) o_ddr_cmd_addr <= o_ddr_cmd_addr + DDR_ADDR_W'(BURST_WORDS * L2_WORD_BYTES);
      o_ddr_cmd_valid <= issue || (o_ddr_cmd_valid && !i_ddr_cmd_ready);
      pending <= pending + (accept ? 10'(BURST_WORDS) : 10'd0) - {9'd0, o_l2_ddr_operate_enable};
      bursts_in_flight <= bursts_in_flight + {7'd0, accept} - {7'd0, burst_done};
      word_cnt <= burst_done ? 7'd0 : word_cnt + {6'd0, o_l2_ddr_operate_enable};
      o_l2_ddr_operate_enable <= i_ddr_rd_valid && !nothing_owed;
      wr_data <= i_ddr_rd_data;
      o_err_unexpected <= o_err_unexpected || (i_ddr_rd_valid && nothing_owed);
    end
  end
  for (genvar i = 0; i < 128; i++) begin : g_lane
    bufif1 u_drv (io_l2_ddr_data_bus[i], wr_data[i], o_l2_ddr_operate_enable);
  end
endmodule
